locked_prio_irq: RTL and testbench
==================================

LOCKED_PRIO_IRQ -- requirements
Module: locked_prio_irq

Interface
REQ-001 SHALL have parameter NCH, default 9: number of request channels, 2..32.
REQ-002 SHALL have parameter KW, default 10: key width in bits, 1..64.
REQ-003 SHALL have derived parameter IDW = max(1, clog2(NCH)): width of the grant index.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port req, input, NCH bits: level interrupt requests; bit 0 has highest priority.
REQ-007 SHALL have port en, input, NCH bits: per-channel enable; 0 masks the channel.
REQ-008 SHALL have port key_bit, input, 1 bit: serial key data, MSB first.
REQ-009 SHALL have port key_load, input, 1 bit: key shift strobe, one key bit per cycle while high.
REQ-010 SHALL have port irq_valid, output, 1 bit: grant valid.
REQ-011 SHALL have port irq_ready, input, 1 bit: consumer accepts the grant.
REQ-012 SHALL have port irq_id, output, IDW bits: index of the granted channel.
REQ-013 SHALL have port irq_any, output, 1 bit: OR of all pending bits.
REQ-014 SHALL have port unlocked, output, 1 bit: high in state ACTIVE only.

Function
REQ-015 SHALL implement FSM states LOCKED, LOAD and ACTIVE.
REQ-016 LOCKED: on key_load=1, SHALL go to LOAD, shift the first bit in and set bit count to 1.
REQ-017 LOAD: on each cycle with key_load=1, SHALL shift key_reg left, taking key_bit into the LSB, and increment the count.
REQ-018 LOAD: when the count reaches KW, SHALL go to ACTIVE on the next edge; if key_load=0 earlier, SHALL go to LOCKED and clear the count (key_reg keeps its value).
REQ-019 ACTIVE: on key_load=1, SHALL go to LOAD, clear all pending bits and deassert irq_valid in the same edge.
REQ-020 SHALL form effective request eff[i] = ~(req[i] ^ key_reg[i mod KW]) & en[i]; a key bit of 1 passes the channel unmodified.
REQ-021 SHALL register eff every cycle; pending bit i SHALL be set on a rising edge of eff[i] in ACTIVE only (edge evaluated against the previous registered value).
REQ-022 Pending bit i SHALL clear on the edge where irq_valid & irq_ready & irq_id==i.
REQ-023 If set and clear hit the same bit in the same cycle, set SHALL win.
REQ-024 When irq_valid=0 or irq_ready=1, the output register SHALL load the lowest-index pending bit, excluding any bit cleared this cycle; irq_valid SHALL be 0 if none remains.
REQ-025 While irq_valid=1 and irq_ready=0, irq_id and irq_valid SHALL hold stable.
REQ-026 Latency: a req edge in cycle t SHALL set pending at t+1 and raise irq_valid at t+2 (eff register counts as t).
REQ-027 Back-to-back: with irq_ready held high, distinct pending channels SHALL be granted one per cycle in priority order.
REQ-028 irq_any SHALL be the registered OR of pending; unlocked SHALL be registered (state==ACTIVE).
REQ-029 In LOCKED and LOAD, irq_valid and irq_any SHALL be 0.

Reset
REQ-030 rst=1 SHALL asynchronously force: state LOCKED, key_reg 0, count 0, pending 0, eff register 0, irq_valid 0, irq_id 0, irq_any 0, unlocked 0.
REQ-031 Reset asserted mid-LOAD or mid-handshake SHALL abandon the transaction; the first cycle after release SHALL behave as after power-up.

Structure
REQ-032 A shared package SHALL hold the state enum (LOCKED/LOAD/ACTIVE) and a clog2-based IDW helper function.
REQ-033 The priority encoder (NCH-bit vector to IDW-bit index plus found flag) SHALL be a sub-module named prio_enc.

Verification
REQ-034 Reset, then key_load for 10 cycles with all bits 1, then req=9'b000000100 -> unlocked=1 at the cycle after the 10th bit; irq_valid=1 and irq_id=2 two cycles after the req edge.
REQ-035 Key bit 2 loaded as 0, then req[2] held low -> eff[2]=1, so pending[2] is set and irq_id=2 granted (inverted channel).
REQ-036 In ACTIVE with irq_ready=1, req=9'b100010001 set in one cycle -> grants irq_id 0, 4, 8 in three consecutive cycles, then irq_valid=0 and irq_any=0.
REQ-037 irq_ready=0 with id 3 valid, then req[1] rises -> irq_id stays 3 until irq_ready=1, then 1 is granted next.
REQ-038 key_load drops after 5 bits -> state LOCKED, unlocked=0, req edges ignored; rst pulsed during a grant -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/locked_prio_irq_pkg.sv
// Shared types and helpers for the key-locked priority interrupt controller.
//   state_e : unlock FSM states
//   idw_f   : grant index width, never less than one bit
package locked_prio_irq_pkg;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  function automatic int unsigned idw_f(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/locked_prio_irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of vec_i wins.
//   vec_i   : candidate vector (bit 0 highest priority)
//   idx_o   : index of the winning bit, 0 when none set
//   found_o : at least one bit of vec_i is set
module prio_enc #(
  parameter int unsigned NCH = 9,
  parameter int unsigned IDW = 4
) (
  input  logic [NCH-1:0] vec_i,
  output logic [IDW-1:0] idx_o,
  output logic           found_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/locked_prio_irq.sv
// Key-locked priority interrupt controller. A serial key must be shifted in
// before requests are accepted; each key bit also selects whether the matching
// request channel is passed straight (1) or inverted (0).
//   clk, rst            : clock, async active-high reset
//   req, en             : level requests (bit 0 highest priority), per-channel enable
//   key_bit, key_load   : serial key, MSB first, one bit per cycle while key_load
//   irq_valid/ready/id  : valid/ready grant handshake carrying the channel index
//   irq_any             : any channel pending
//   unlocked            : controller is in ACTIVE
module locked_prio_irq
  import locked_prio_irq_pkg::*;
#(
  parameter int unsigned NCH = 9,
  parameter int unsigned KW  = 10,
  parameter int unsigned IDW = idw_f(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] en,
  input  logic           key_bit,
  input  logic           key_load,
  output logic           irq_valid,
  input  logic           irq_ready,
  output logic [IDW-1:0] irq_id,
  output logic           irq_any,
  output logic           unlocked
);

  localparam int unsigned CNTW = $clog2(KW + 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   key_q, key_d, key_shift_c;
  logic [NCH-1:0]  eff_c, eff_q;
  logic [NCH-1:0]  pend_q, pend_d;
  logic [NCH-1:0]  set_c, clr_c, cand_c;
  logic            valid_q, valid_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            any_q, any_d;
  logic            unl_q, unl_d;
  logic            active_c;
  logic [IDW-1:0]  idx_c;
  logic            found_c;

  // Truncating cast drops the old MSB, so this also works for KW == 1.
  assign key_shift_c = KW'({key_q, key_bit});

  // Effective request: key bit 1 passes the channel, 0 inverts it.
  for (genvar i = 0; i < NCH; i++) begin : g_eff
    assign eff_c[i] = ~(req[i] ^ key_q[i % KW]) & en[i];
  end

  // Unlock FSM and key shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    unique case (state_q)
      LOCKED, ACTIVE: begin
        if (key_load) begin
          state_d = LOAD;
          key_d   = key_shift_c;
          cnt_d   = CNTW'(1);
        end
      end
      LOAD: begin
        if (cnt_q == CNTW'(KW)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else if (key_load) begin
          key_d = key_shift_c;
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          state_d = LOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  // Pending set/clear and the grant output register.
  always_comb begin
    // Leaving ACTIVE this edge wipes pending and the grant in the same edge.
    active_c = (state_q == ACTIVE) && (state_d == ACTIVE);
    set_c    = active_c ? (eff_c & ~eff_q) : '0;
    clr_c    = (valid_q && irq_ready) ? (NCH'(1) << id_q) : '0;
    // Set after clear: a re-raised request survives its own acknowledge.
    pend_d   = active_c ? ((pend_q & ~clr_c) | set_c) : '0;
    cand_c   = pend_q & ~clr_c;
    valid_d  = valid_q;
    id_d     = id_q;
    if (!active_c) begin
      valid_d = 1'b0;
      id_d    = '0;
    end else if (!valid_q || irq_ready) begin
      valid_d = found_c;
      id_d    = idx_c;
    end
    any_d = |pend_d;
    unl_d = (state_d == ACTIVE);
  end

  prio_enc #(
    .NCH(NCH),
    .IDW(IDW)
  ) u_prio_enc (
    .vec_i  (cand_c),
    .idx_o  (idx_c),
    .found_o(found_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOCKED;
      cnt_q   <= '0;
      key_q   <= '0;
      eff_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      any_q   <= 1'b0;
      unl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      eff_q   <= eff_c;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      any_q   <= any_d;
      unl_q   <= unl_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign irq_any   = any_q;
  assign unlocked  = unl_q;

endmodule

// File: tb/tb_locked_prio_irq.sv
// Directed bench for locked_prio_irq with hand-computed expectations.
module tb_locked_prio_irq;

  localparam int unsigned NCH = 9;
  localparam int unsigned KW  = 10;
  localparam int unsigned IDW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] req;
  logic [NCH-1:0] en;
  logic           key_bit;
  logic           key_load;
  logic           irq_valid;
  logic           irq_ready;
  logic [IDW-1:0] irq_id;
  logic           irq_any;
  logic           unlocked;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  locked_prio_irq #(
    .NCH(NCH),
    .KW (KW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .key_bit  (key_bit),
    .key_load (key_load),
    .irq_valid(irq_valid),
    .irq_ready(irq_ready),
    .irq_id   (irq_id),
    .irq_any  (irq_any),
    .unlocked (unlocked)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Grant index is only meaningful while valid is expected high.
  task automatic check_out(input string tag, input logic v, input int id,
                           input logic any, input logic unl);
    check_val({tag, ".valid"}, 64'(irq_valid), 64'(v));
    if (v) check_val({tag, ".id"}, 64'(irq_id), 64'(id));
    check_val({tag, ".any"}, 64'(irq_any), 64'(any));
    check_val({tag, ".unlocked"}, 64'(unlocked), 64'(unl));
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, ".valid"}, 64'(irq_valid), 64'd0);
    check_val({tag, ".id"}, 64'(irq_id), 64'd0);
    check_val({tag, ".any"}, 64'(irq_any), 64'd0);
    check_val({tag, ".unlocked"}, 64'(unlocked), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift the top nbits of key in MSB first; key_load is left low afterwards.
  task automatic load_key(input logic [KW-1:0] key, input int nbits, input bit chk_first);
    for (int i = 0; i < nbits; i++) begin
      key_load = 1'b1;
      key_bit  = key[KW-1-i];
      step();
      if (chk_first && i == 0) check_out("load_entry", 1'b0, 0, 1'b0, 1'b0);
    end
    key_load = 1'b0;
    key_bit  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    en        = '1;
    key_bit   = 1'b0;
    key_load  = 1'b0;
    irq_ready = 1'b0;
    #1;
    check_reset("por");
    step();
    step();
    rst = 1'b0;
    step();
    check_out("locked_idle", 1'b0, 0, 1'b0, 1'b0);

    // Unlock with an all-ones key.
    load_key(10'h3FF, 10, 1'b0);
    check_val("unl_before_done", 64'(unlocked), 64'd0);
    step();
    check_val("unl_after_key", 64'(unlocked), 64'd1);

    // Single request latency.
    req = 9'b000000100;
    step();
    check_out("lat_t1", 1'b0, 0, 1'b1, 1'b1);
    step();
    check_out("lat_t2", 1'b1, 2, 1'b1, 1'b1);
    irq_ready = 1'b1;
    step();
    check_out("ack2", 1'b0, 0, 1'b0, 1'b1);
    req = '0;
    step();

    // Back-to-back grants in priority order.
    req = 9'b100010001;
    step();
    check_out("b2b_set", 1'b0, 0, 1'b1, 1'b1);
    step();
    check_out("b2b_0", 1'b1, 0, 1'b1, 1'b1);
    step();
    check_out("b2b_4", 1'b1, 4, 1'b1, 1'b1);
    step();
    check_out("b2b_8", 1'b1, 8, 1'b1, 1'b1);
    step();
    check_out("b2b_done", 1'b0, 0, 1'b0, 1'b1);
    req       = '0;
    irq_ready = 1'b0;
    step();

    // Grant holds under back-pressure, higher priority follows on ready.
    req = 9'b000001000;
    step();
    step();
    check_out("hold_3", 1'b1, 3, 1'b1, 1'b1);
    req = 9'b000001010;
    step();
    check_out("hold_3b", 1'b1, 3, 1'b1, 1'b1);
    step();
    check_out("hold_3c", 1'b1, 3, 1'b1, 1'b1);
    irq_ready = 1'b1;
    step();
    check_out("next_1", 1'b1, 1, 1'b1, 1'b1);
    step();
    check_out("drain", 1'b0, 0, 1'b0, 1'b1);
    req       = '0;
    irq_ready = 1'b0;
    step();

    // Rekey during a live grant, then channel 2 inverted by a 0 key bit.
    req = 9'b000100000;
    step();
    step();
    check_out("grant5", 1'b1, 5, 1'b1, 1'b1);
    req = 9'b000000100;
    load_key(10'b1111111011, 10, 1'b1);
    step();
    check_out("reunlock", 1'b0, 0, 1'b0, 1'b1);
    req = '0;
    step();
    check_out("inv_set", 1'b0, 0, 1'b1, 1'b1);
    step();
    check_out("inv_grant", 1'b1, 2, 1'b1, 1'b1);
    irq_ready = 1'b1;
    step();
    check_out("inv_ack", 1'b0, 0, 1'b0, 1'b1);
    irq_ready = 1'b0;

    // Aborted key load falls back to LOCKED and ignores requests.
    load_key(10'h3FF, 5, 1'b1);
    step();
    check_out("abort_locked", 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      req = k[0] ? '0 : 9'h1FF;
      step();
      check_out("locked_ignore", 1'b0, 0, 1'b0, 1'b0);
    end

    // Async reset in the middle of a grant.
    req = '0;
    load_key(10'h3FF, 10, 1'b0);
    step();
    check_val("unl3", 64'(unlocked), 64'd1);
    req = 9'b010000000;
    step();
    step();
    check_out("grant7", 1'b1, 7, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("rst_grant");
    req = '0;
    rst = 1'b0;
    step();
    check_out("post_rst", 1'b0, 0, 1'b0, 1'b0);

    // Async reset mid-load: full key count needed again afterwards.
    load_key(10'h3FF, 3, 1'b0);
    rst = 1'b1;
    #1;
    check_reset("rst_load");
    rst = 1'b0;
    load_key(10'h3FF, 10, 1'b0);
    check_val("relock_cnt", 64'(unlocked), 64'd0);
    step();
    check_val("relock_unl", 64'(unlocked), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
